bcd_countdown_timer: RTL and testbench

BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

---
 rtl/bcd_timer_pkg.sv | 20 ++
 rtl/bcd_cd_prescaler.sv | 28 ++
 rtl/bcd_countdown_timer.sv | 135 +++++++++++++
 tb/tb_bcd_countdown_timer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_timer_pkg.sv
// Shared definitions for the BCD countdown timer: state encoding, digit width
// and the digit clamp used when presets are loaded.
package bcd_timer_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] digit,
                                                     input logic [BCD_W-1:0] limit);
        return (digit > limit) ? limit : digit;
    endfunction

endpackage

// File: rtl/bcd_cd_prescaler.sv
// Decrement-tick prescaler: counts 0..TICK_DIV-1 while enabled and flags the
// terminal count combinationally so the tick lands on the same edge as the wrap.
module bcd_cd_prescaler #(
    parameter logic [3:0] TICK_DIV = 4'd10
) (
    input  logic i_Clk,
    input  logic r_Rst,
    input  logic i_Clear,
    input  logic i_Enable,
    output logic o_Tick
);

    logic [3:0] count;

    assign o_Tick = i_Enable && (count == TICK_DIV - 4'd1);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_Clk) begin
        if (r_Rst) begin
            count <= 4'd0;
        end else if (i_Clear) begin
            count <= 4'd0;
        end else if (i_Enable) begin
            count <= o_Tick ? 4'd0 : count + 4'd1;
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer with load/start/pause control and borrow/done flags.
// Optional feature: define BCD_COUNTDOWN_AUTORELOAD_EN to reload the last preset on reaching 00.
module bcd_countdown_timer
    import bcd_timer_pkg::*;
#(
    parameter logic [3:0] TICK_DIV = 4'd10,
    parameter logic [3:0] MAX_TENS = 4'd5
) (
    input  logic             i_Clk,
    input  logic             r_Rst,
    input  logic             i_Load,
    input  logic [BCD_W-1:0] i_LdTens,
    input  logic [BCD_W-1:0] i_LdUnits,
    input  logic             i_Start,
    input  logic             i_Pause,
    output logic [BCD_W-1:0] o_Tens,
    output logic [BCD_W-1:0] o_Units,
    output logic             o_Borrow,
    output logic             o_Done,
    output logic [1:0]       o_State
);

    localparam logic [BCD_W-1:0] TENS_LIM = (MAX_TENS > BCD_MAX) ? BCD_MAX : MAX_TENS;

    state_t           state, state_nx;
    logic [BCD_W-1:0] tens, units, tens_nx, units_nx;
    logic [BCD_W-1:0] ld_tens, ld_units;
    logic             borrow, borrow_nx, done, done_nx, reload_pulse;
    logic             presc_en, tick;

    assign ld_tens  = clamp_digit(i_LdTens, TENS_LIM);
    assign ld_units = clamp_digit(i_LdUnits, BCD_MAX);

    // Pause outranks the tick, so gating the enable both holds the count and drops the tick.
    assign presc_en = (state == ST_RUN) && !i_Load && !i_Pause;

    bcd_cd_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .i_Clk    (i_Clk),
        .r_Rst    (r_Rst),
        .i_Clear  (i_Load),
        .i_Enable (presc_en),
        .o_Tick   (tick)
    );

`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
    logic [BCD_W-1:0] rl_tens, rl_units;

    always_ff @(posedge i_Clk) begin
        if (r_Rst) begin
            rl_tens  <= '0;
            rl_units <= '0;
        end else if (i_Load) begin
            rl_tens  <= ld_tens;
            rl_units <= ld_units;
        end
    end
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx     = state;
        tens_nx      = tens;
        units_nx     = units;
        borrow_nx    = 1'b0;
        reload_pulse = 1'b0;
        if (i_Load) begin
            tens_nx  = ld_tens;
            units_nx = ld_units;
            state_nx = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (i_Start) begin
                        state_nx = (tens != '0 || units != '0) ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    if (i_Pause) begin
                        state_nx = ST_PAUSE;
                    end else if (tick) begin
                        if (units != '0) begin
                            units_nx = units - 4'd1;
                        end else if (tens != '0) begin
                            units_nx  = BCD_MAX;
                            tens_nx   = tens - 4'd1;
                            borrow_nx = 1'b1;
                        end
                        if (tens == '0 && units == 4'd1) begin
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
                            tens_nx      = rl_tens;
                            units_nx     = rl_units;
                            reload_pulse = 1'b1;
`else
                            state_nx = ST_DONE;
`endif
                        end
                    end
                end
                ST_PAUSE: begin
                    if (i_Start) begin
                        state_nx = ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_nx = ST_DONE;
                end
            endcase
        end
        done_nx = (state_nx == ST_DONE) || reload_pulse;
    end

    // NOTE: only control/datapath flops live here and all take reset; there is no memory to leave unreset.
    always_ff @(posedge i_Clk) begin
        if (r_Rst) begin
            state  <= ST_IDLE;
            tens   <= '0;
            units  <= '0;
            borrow <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            tens   <= tens_nx;
            units  <= units_nx;
            borrow <= borrow_nx;
            done   <= done_nx;
        end
    end

    assign o_Tens   = tens;
    assign o_Units  = units;
    assign o_Borrow = borrow;
    assign o_Done   = done;
    assign o_State  = state;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer with TICK_DIV=4; snapshots are packed as
// {tens[3:0], units[3:0], state[1:0], borrow, done}.
module tb_bcd_countdown_timer;

    logic       i_Clk = 1'b0;
    logic       r_Rst = 1'b0;
    logic       i_Load = 1'b0;
    logic       i_Start = 1'b0;
    logic       i_Pause = 1'b0;
    logic [3:0] i_LdTens = 4'd0;
    logic [3:0] i_LdUnits = 4'd0;
    logic [3:0] o_Tens, o_Units;
    logic       o_Borrow, o_Done;
    logic [1:0] o_State;

    int checks = 0;
    int failures = 0;

    bcd_countdown_timer #(.TICK_DIV(4'd4), .MAX_TENS(4'd5)) dut (
        .i_Clk     (i_Clk),
        .r_Rst     (r_Rst),
        .i_Load    (i_Load),
        .i_LdTens  (i_LdTens),
        .i_LdUnits (i_LdUnits),
        .i_Start   (i_Start),
        .i_Pause   (i_Pause),
        .o_Tens    (o_Tens),
        .o_Units   (o_Units),
        .o_Borrow  (o_Borrow),
        .o_Done    (o_Done),
        .o_State   (o_State)
    );

    always #5 i_Clk = ~i_Clk;

    function automatic logic [11:0] snap();
        return {o_Tens, o_Units, o_State, o_Borrow, o_Done};
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge i_Clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [3:0] t, input logic [3:0] u);
        i_LdTens = t;
        i_LdUnits = u;
        i_Load = 1'b1;
        step();
        i_Load = 1'b0;
    endtask

    task automatic do_start();
        i_Start = 1'b1;
        step();
        i_Start = 1'b0;
    endtask

    task automatic test_reset();
        r_Rst = 1'b1;
        step(2);
        r_Rst = 1'b0;
        checks++;
        if (snap() !== 12'h000) begin
            failures++;
            $display("FAIL reset: got=%h exp=%h", snap(), 12'h000);
        end
    endtask

    task automatic test_clamp();
        do_load(4'd9, 4'd12);
        checks++;
        if (snap() !== 12'h590) begin
            failures++;
            $display("FAIL clamp: got=%h exp=%h", snap(), 12'h590);
        end
    endtask

    task automatic test_count_borrow();
        logic [11:0] tbl [13] = '{12'h124, 12'h124, 12'h124, 12'h114, 12'h114, 12'h114, 12'h114,
                                  12'h104, 12'h104, 12'h104, 12'h104, 12'h096, 12'h094};
        do_load(4'd1, 4'd2);
        do_start();
        for (int k = 1; k <= 13; k++) begin
            step();
            checks++;
            if (snap() !== tbl[k-1]) begin
                failures++;
                $display("FAIL count_borrow cycle %0d: got=%h exp=%h", k, snap(), tbl[k-1]);
            end
        end
    endtask

    task automatic test_start_zero();
        do_load(4'd0, 4'd0);
        do_start();
        checks++;
        if (snap() !== 12'h00D) begin
            failures++;
            $display("FAIL start_zero: got=%h exp=%h", snap(), 12'h00D);
        end
    endtask

`ifndef BCD_COUNTDOWN_AUTORELOAD_EN
    task automatic test_done();
        do_load(4'd0, 4'd1);
        do_start();
        step(3);
        checks++;
        if (snap() !== 12'h014) begin
            failures++;
            $display("FAIL done_before: got=%h exp=%h", snap(), 12'h014);
        end
        step();
        checks++;
        if (snap() !== 12'h00D) begin
            failures++;
            $display("FAIL done_reach: got=%h exp=%h", snap(), 12'h00D);
        end
        do_start();
        i_Pause = 1'b1;
        step();
        i_Pause = 1'b0;
        checks++;
        if (snap() !== 12'h00D) begin
            failures++;
            $display("FAIL done_hold: got=%h exp=%h", snap(), 12'h00D);
        end
        do_load(4'd0, 4'd3);
        checks++;
        if (snap() !== 12'h030) begin
            failures++;
            $display("FAIL done_exit_load: got=%h exp=%h", snap(), 12'h030);
        end
    endtask
`else
    task automatic test_autoreload();
        logic [11:0] tbl [9] = '{12'h024, 12'h024, 12'h024, 12'h014, 12'h014, 12'h014, 12'h014,
                                 12'h025, 12'h024};
        do_load(4'd0, 4'd2);
        do_start();
        for (int k = 1; k <= 9; k++) begin
            step();
            checks++;
            if (snap() !== tbl[k-1]) begin
                failures++;
                $display("FAIL autoreload cycle %0d: got=%h exp=%h", k, snap(), tbl[k-1]);
            end
        end
    endtask
`endif

    task automatic test_pause_resume();
        int n;
        logic [11:0] exp_end;
        do_load(4'd0, 4'd5);
        do_start();
        step(6);
        i_Pause = 1'b1;
        step();
        i_Pause = 1'b0;
        checks++;
        if (snap() !== 12'h048) begin
            failures++;
            $display("FAIL pause_enter: got=%h exp=%h", snap(), 12'h048);
        end
        step(20);
        checks++;
        if (snap() !== 12'h048) begin
            failures++;
            $display("FAIL pause_hold: got=%h exp=%h", snap(), 12'h048);
        end
        do_start();
        checks++;
        if (snap() !== 12'h044) begin
            failures++;
            $display("FAIL pause_resume: got=%h exp=%h", snap(), 12'h044);
        end
        n = 0;
        while (n < 40 && o_Done !== 1'b1) begin
            step();
            n++;
        end
        checks++;
        if (n != 14) begin
            failures++;
            $display("FAIL resume_latency: got=%0d cycles exp=%0d", n, 14);
        end
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
        exp_end = 12'h055;
`else
        exp_end = 12'h00D;
`endif
        checks++;
        if (snap() !== exp_end) begin
            failures++;
            $display("FAIL resume_end: got=%h exp=%h", snap(), exp_end);
        end
    endtask

    task automatic test_pause_tick();
        do_load(4'd0, 4'd5);
        do_start();
        step(3);
        i_Pause = 1'b1;
        step();
        i_Pause = 1'b0;
        checks++;
        if (snap() !== 12'h058) begin
            failures++;
            $display("FAIL pause_tick_drop: got=%h exp=%h", snap(), 12'h058);
        end
        do_start();
        step();
        checks++;
        if (snap() !== 12'h044) begin
            failures++;
            $display("FAIL pause_tick_resume: got=%h exp=%h", snap(), 12'h044);
        end
    endtask

    task automatic test_load_clears_prescaler();
        do_load(4'd0, 4'd9);
        do_start();
        step(2);
        do_load(4'd0, 4'd9);
        checks++;
        if (snap() !== 12'h090) begin
            failures++;
            $display("FAIL reload_idle: got=%h exp=%h", snap(), 12'h090);
        end
        do_start();
        step(3);
        checks++;
        if (snap() !== 12'h094) begin
            failures++;
            $display("FAIL presc_cleared: got=%h exp=%h", snap(), 12'h094);
        end
        step();
        checks++;
        if (snap() !== 12'h084) begin
            failures++;
            $display("FAIL presc_first_tick: got=%h exp=%h", snap(), 12'h084);
        end
    endtask

    task automatic test_reset_priority();
        do_load(4'd0, 4'd9);
        do_start();
        step(5);
        checks++;
        if (snap() !== 12'h084) begin
            failures++;
            $display("FAIL rst_pre: got=%h exp=%h", snap(), 12'h084);
        end
        r_Rst = 1'b1;
        i_Load = 1'b1;
        i_LdTens = 4'd3;
        i_LdUnits = 4'd3;
        step();
        r_Rst = 1'b0;
        i_Load = 1'b0;
        checks++;
        if (snap() !== 12'h000) begin
            failures++;
            $display("FAIL rst_load: got=%h exp=%h", snap(), 12'h000);
        end
        step(4);
        checks++;
        if (snap() !== 12'h000) begin
            failures++;
            $display("FAIL rst_idle_hold: got=%h exp=%h", snap(), 12'h000);
        end
    endtask

    initial begin
        test_reset();
        test_clamp();
        test_count_borrow();
        test_start_zero();
`ifndef BCD_COUNTDOWN_AUTORELOAD_EN
        test_done();
`else
        test_autoreload();
`endif
        test_pause_resume();
        test_pause_tick();
        test_load_clears_prescaler();
        test_reset_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
